// File: rtl/mixffn_seq_ctrl.sv
// Sequencer for the Mix-FFN datapath: paces fc1 input bursts per token, forwards
// the stage strobes with their weight indices, and tracks final outputs to end a run.
module mixffn_seq_ctrl #(
    parameter int TOK_LEN = 64,
    parameter int CH      = 256,
    parameter int N_TOK   = 32,
    parameter int GAP     = 192
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       src_valid,
    input  logic                       out_valid_fc1,
    input  logic                       out_valid_dwconv,
    input  logic                       out_valid_gelu,
    input  logic                       out_valid,
    output logic                       in_valid_fc1,
    output logic [$clog2(TOK_LEN)-1:0] fc1_waddr,
    output logic                       in_valid_dwconv,
    output logic                       in_valid_gelu,
    output logic                       in_valid_fc2,
    output logic [$clog2(CH)-1:0]      conv_waddr,
    output logic [$clog2(CH)-1:0]      fc2_waddr,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int FW    = $clog2(TOK_LEN);
    localparam int CW    = $clog2(CH);
    localparam int TOTAL = N_TOK * TOK_LEN;
    localparam int OW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(N_TOK + 1);
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [FW-1:0] FC1_LAST  = FW'(TOK_LEN - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);
    localparam logic [OW-1:0] OUT_TOTAL = OW'(TOTAL);
    localparam logic [TW-1:0] TOK_TOTAL = TW'(N_TOK);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FC1,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [FW-1:0] r_fc1_waddr;
    logic [TW-1:0] r_tok_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [OW-1:0] r_out_cnt;
    logic          r_done;
    logic          r_err;

    logic          w_busy;
    logic          w_start;
    logic          w_fc1_beat;
    logic          w_out_full;
    logic          w_out_inc;
    logic          w_out_err;
    logic [OW-1:0] w_out_cnt_next;

    assign w_busy     = (r_state != S_IDLE);
    assign w_start    = (r_state == S_IDLE) && start;
    assign w_fc1_beat = (r_state == S_FC1) && src_valid;

    // The count saturates at the run total; any beat beyond it is a protocol error.
    assign w_out_full     = (r_out_cnt == OUT_TOTAL);
    assign w_out_inc      = w_busy && out_valid && !w_out_full;
    assign w_out_err      = out_valid && (!w_busy || w_out_full);
    assign w_out_cnt_next = w_out_inc ? (r_out_cnt + OW'(1)) : r_out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fc1_waddr <= '0;
            r_tok_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_out_cnt   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_out_cnt <= w_out_cnt_next;
            if (w_out_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FC1;
                        r_fc1_waddr <= '0;
                        r_tok_cnt   <= '0;
                        r_gap_cnt   <= '0;
                        r_out_cnt   <= '0;
                        r_err       <= 1'b0;
                    end
                end
                S_FC1: begin
                    if (src_valid) begin
                        if (r_fc1_waddr == FC1_LAST) begin
                            r_fc1_waddr <= '0;
                            r_tok_cnt   <= r_tok_cnt + TW'(1);
                            r_gap_cnt   <= '0;
                            r_state     <= S_GAP;
                        end else begin
                            r_fc1_waddr <= r_fc1_waddr + FW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= (r_tok_cnt < TOK_TOTAL) ? S_FC1 : S_DRAIN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_DRAIN: begin
                    // Compare the post-beat count so a beat landing this cycle ends the run.
                    if (w_out_cnt_next == OUT_TOTAL) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic r_iv_dwconv;
    logic r_iv_gelu;
    logic r_iv_fc2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iv_dwconv <= 1'b0;
            r_iv_gelu   <= 1'b0;
            r_iv_fc2    <= 1'b0;
        end else begin
            r_iv_dwconv <= out_valid_fc1;
            r_iv_gelu   <= out_valid_dwconv;
            r_iv_fc2    <= out_valid_gelu;
        end
    end

    // Lane 0 indexes dwconv channels, lane 1 indexes fc2 weight columns.
    logic [1:0]    w_lane_beat;
    logic [CW-1:0] r_lane_addr [2];

    assign w_lane_beat = {r_iv_fc2, r_iv_dwconv};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane_addr[gi] <= '0;
                end else if (w_start) begin
                    r_lane_addr[gi] <= '0;
                end else if (w_lane_beat[gi]) begin
                    r_lane_addr[gi] <= (r_lane_addr[gi] == CH_LAST) ? '0 : (r_lane_addr[gi] + CW'(1));
                end
            end
        end
    endgenerate

    assign in_valid_fc1    = w_fc1_beat;
    assign fc1_waddr       = r_fc1_waddr;
    assign in_valid_dwconv = r_iv_dwconv;
    assign in_valid_gelu   = r_iv_gelu;
    assign in_valid_fc2    = r_iv_fc2;
    assign conv_waddr      = r_lane_addr[0];
    assign fc2_waddr       = r_lane_addr[1];
    assign busy            = w_busy;
    assign done            = r_done;
    assign err             = r_err;

endmodule

// File: tb/tb_mixffn_seq_ctrl.sv
// Self-checking bench for mixffn_seq_ctrl: stage-strobe vector table, weight-index
// scoreboard, and hand-written burst, stall, drain, error and reset sequences.
module tb_mixffn_seq_ctrl;

    localparam int TOK_LEN = 64;
    localparam int CH      = 256;
    localparam int N_TOK   = 2;
    localparam int GAP     = 192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       src_valid;
    logic       out_valid_fc1;
    logic       out_valid_dwconv;
    logic       out_valid_gelu;
    logic       out_valid;
    logic       in_valid_fc1;
    logic [5:0] fc1_waddr;
    logic       in_valid_dwconv;
    logic       in_valid_gelu;
    logic       in_valid_fc2;
    logic [7:0] conv_waddr;
    logic [7:0] fc2_waddr;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    mixffn_seq_ctrl #(
        .TOK_LEN(TOK_LEN),
        .CH     (CH),
        .N_TOK  (N_TOK),
        .GAP    (GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .src_valid       (src_valid),
        .out_valid_fc1   (out_valid_fc1),
        .out_valid_dwconv(out_valid_dwconv),
        .out_valid_gelu  (out_valid_gelu),
        .out_valid       (out_valid),
        .in_valid_fc1    (in_valid_fc1),
        .fc1_waddr       (fc1_waddr),
        .in_valid_dwconv (in_valid_dwconv),
        .in_valid_gelu   (in_valid_gelu),
        .in_valid_fc2    (in_valid_fc2),
        .conv_waddr      (conv_waddr),
        .fc2_waddr       (fc2_waddr),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int q_conv[$];
    int q_fc2[$];
    int m_conv = 0;
    int m_fc2  = 0;
    int beats_sent  = 0;
    int beat_budget = 0;

    typedef struct {
        logic [2:0] stim;  // {out_valid_fc1, out_valid_dwconv, out_valid_gelu}
        logic [2:0] exp;   // {in_valid_dwconv, in_valid_gelu, in_valid_fc2} one cycle later
    } vec_t;
    vec_t tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each strobe beat must carry the index that was queued when it was driven.
    always @(negedge clk) begin
        if (in_valid_dwconv) begin
            if (q_conv.size() == 0) check("conv_sb_unexpected", 1, 0);
            else check("conv_waddr_sb", 32'(conv_waddr), 32'(q_conv.pop_front()));
        end
        if (in_valid_fc2) begin
            if (q_fc2.size() == 0) check("fc2_sb_unexpected", 1, 0);
            else check("fc2_waddr_sb", 32'(fc2_waddr), 32'(q_fc2.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_stage(input logic a, input logic b, input logic c);
        out_valid_fc1    = a;
        out_valid_dwconv = b;
        out_valid_gelu   = c;
        if (a) begin
            q_conv.push_back(m_conv);
            m_conv = (m_conv + 1) % CH;
        end
        if (c) begin
            q_fc2.push_back(m_fc2);
            m_fc2 = (m_fc2 + 1) % CH;
        end
    endtask

    task automatic drive_run(input logic sv);
        start     = 1'b0;
        src_valid = sv;
        out_valid = (beats_sent < beat_budget);
        if (out_valid) beats_sent++;
        #1;
    endtask

    task automatic start_run();
        next_cycle();
        drive_stage(1'b0, 1'b0, 1'b0);
        start     = 1'b1;
        src_valid = 1'b1;
        out_valid = 1'b0;
        #1;
        check("start_cycle_busy", 32'(busy), 0);
        check("start_cycle_fc1", 32'(in_valid_fc1), 0);
        beats_sent = 0;
        m_conv     = 0;
        m_fc2      = 0;
    endtask

    // One token: the fc1 burst (with an optional source stall) then the idle gap.
    task automatic run_token(input int stall_at, input int stall_len, input bit bonus);
        int  k;
        logic sv;
        k = 0;
        for (int c = 0; c < TOK_LEN + stall_len; c++) begin
            next_cycle();
            sv = !(c >= stall_at && c < stall_at + stall_len);
            drive_run(sv);
            check("fc1_strobe", 32'(in_valid_fc1), 32'(sv));
            check("fc1_waddr", 32'(fc1_waddr), 32'(k));
            check("run_busy", 32'(busy), 1);
            check("run_err", 32'(err), 0);
            if (sv) k++;
        end
        for (int g = 0; g < GAP; g++) begin
            next_cycle();
            if (bonus && g == GAP - 1) beat_budget++;
            drive_run(1'b1);
            check("gap_fc1_low", 32'(in_valid_fc1), 0);
            check("gap_busy", 32'(busy), 1);
        end
    endtask

    initial begin
        tab[0] = '{3'b001, 3'b001};
        tab[1] = '{3'b010, 3'b010};
        tab[2] = '{3'b100, 3'b100};
        tab[3] = '{3'b111, 3'b111};
        tab[4] = '{3'b101, 3'b101};
        tab[5] = '{3'b011, 3'b011};
        tab[6] = '{3'b110, 3'b110};
        tab[7] = '{3'b000, 3'b000};

        // Reset with start held high: nothing may happen.
        rst_n = 1'b0;
        start = 1'b1;
        src_valid = 1'b1;
        out_valid = 1'b0;
        out_valid_fc1 = 1'b0;
        out_valid_dwconv = 1'b0;
        out_valid_gelu = 1'b0;
        repeat (3) next_cycle();
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_fc1", 32'(in_valid_fc1), 0);
        check("rst_fc1_waddr", 32'(fc1_waddr), 0);
        check("rst_conv_waddr", 32'(conv_waddr), 0);
        check("rst_fc2_waddr", 32'(fc2_waddr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stage", 32'({in_valid_dwconv, in_valid_gelu, in_valid_fc2}), 0);
        next_cycle();
        rst_n = 1'b1;
        start = 1'b0;
        src_valid = 1'b0;

        // Index wrap: 300 back-to-back beats on the dwconv and fc2 lanes.
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            drive_stage(1'b1, 1'b0, 1'b1);
            #1;
            if (i == 0) check("dw_lag_first", 32'(in_valid_dwconv), 0);
            if (i == 1) begin
                check("dw_lag_second", 32'(in_valid_dwconv), 1);
                check("conv_first_idx", 32'(conv_waddr), 0);
            end
            if (i == 256) check("conv_idx_255", 32'(conv_waddr), 255);
            if (i == 257) check("conv_idx_wrap", 32'(conv_waddr), 0);
        end
        next_cycle();
        drive_stage(1'b0, 1'b0, 1'b0);
        #1;
        check("conv_last_idx", 32'(conv_waddr), 43);
        check("fc2_last_idx", 32'(fc2_waddr), 43);
        check("dw_last_beat", 32'(in_valid_dwconv), 1);
        next_cycle();
        #1;
        check("dw_after_burst", 32'(in_valid_dwconv), 0);
        check("conv_after_burst", 32'(conv_waddr), 44);

        // Stage strobe vectors: each output follows its input one cycle later.
        for (int i = 0; i <= 8; i++) begin
            next_cycle();
            if (i < 8) drive_stage(tab[i].stim[2], tab[i].stim[1], tab[i].stim[0]);
            else drive_stage(1'b0, 1'b0, 1'b0);
            #1;
            if (i > 0) check("stage_vec", 32'({in_valid_dwconv, in_valid_gelu, in_valid_fc2}), 32'(tab[i-1].exp));
        end

        // Protocol error: final output strobe while idle.
        next_cycle();
        out_valid = 1'b1;
        #1;
        check("err_before_edge", 32'(err), 0);
        next_cycle();
        out_valid = 1'b0;
        #1;
        check("err_set", 32'(err), 1);
        check("err_idle_busy", 32'(busy), 0);
        repeat (4) begin
            next_cycle();
            #1;
            check("err_sticky", 32'(err), 1);
        end

        // Run 1: second token stalls at element 10; the final beat lands on the last gap cycle.
        beat_budget = 127;
        start_run();
        check("err_held_at_start", 32'(err), 1);
        run_token(TOK_LEN, 0, 1'b0);
        run_token(10, 5, 1'b1);
        next_cycle();
        drive_run(1'b1);
        check("drain1_busy", 32'(busy), 1);
        check("drain1_done", 32'(done), 0);
        next_cycle();
        drive_run(1'b1);
        check("done1_pulse", 32'(done), 1);
        check("done1_busy_low", 32'(busy), 0);
        next_cycle();
        drive_run(1'b1);
        check("done1_single", 32'(done), 0);
        check("idle_fc1_low", 32'(in_valid_fc1), 0);
        check("run1_err", 32'(err), 0);

        // Run 2: one output still missing at DRAIN entry, so the run waits for it.
        beat_budget = 127;
        start_run();
        run_token(TOK_LEN, 0, 1'b0);
        run_token(TOK_LEN, 0, 1'b0);
        repeat (3) begin
            next_cycle();
            drive_run(1'b1);
            check("drain_wait_busy", 32'(busy), 1);
            check("drain_wait_done", 32'(done), 0);
        end
        beat_budget = 128;
        next_cycle();
        drive_run(1'b1);
        check("drain_last_beat_busy", 32'(busy), 1);
        next_cycle();
        drive_run(1'b1);
        check("done2_pulse", 32'(done), 1);
        check("done2_busy_low", 32'(busy), 0);
        next_cycle();
        drive_run(1'b1);
        check("done2_single", 32'(done), 0);
        check("run2_err", 32'(err), 0);

        // Reset mid-FC1 at element 30, with start held during reset.
        beat_budget = 0;
        start_run();
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            drive_run(1'b1);
            check("pre_rst_waddr", 32'(fc1_waddr), 32'(c));
        end
        next_cycle();
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("midrst_fc1", 32'(in_valid_fc1), 0);
        check("midrst_waddr", 32'(fc1_waddr), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (3) begin
            next_cycle();
            #1;
            check("rst_start_ignored", 32'(busy), 0);
        end
        next_cycle();
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) begin
            next_cycle();
            #1;
            check("post_rst_fc1", 32'(in_valid_fc1), 0);
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_done", 32'(done), 0);
        end

        check("conv_sb_drained", 32'(q_conv.size()), 0);
        check("fc2_sb_drained", 32'(q_fc2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mixffn_seq_ctrl.md
MIXFFN_SEQ_CTRL -- requirements
Module: mixffn_seq_ctrl

Interface
REQ-001 SHALL have parameter TOK_LEN, default 64, meaning input elements per token for the fc1 burst and final outputs per token.
REQ-002 SHALL have parameter CH, default 256, meaning the depthwise-conv and fc2 weight-column count.
REQ-003 SHALL have parameter N_TOK, default 32, meaning tokens per run.
REQ-004 SHALL have parameter GAP, default 192, meaning the minimum idle cycles between fc1 bursts.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-008 SHALL have port src_valid, input, 1 bit: the input-element source has data this cycle.
REQ-009 SHALL have ports out_valid_fc1, out_valid_dwconv and out_valid_gelu, input, 1 bit each: datapath stage output strobes.
REQ-010 SHALL have port out_valid, input, 1 bit: final fc2 output strobe.
REQ-011 SHALL have port in_valid_fc1, output, 1 bit: fc1 input strobe; it is also the src pop.
REQ-012 SHALL have port fc1_waddr, output, $clog2(TOK_LEN) bits: fc1 weight/element index.
REQ-013 SHALL have ports in_valid_dwconv, in_valid_gelu and in_valid_fc2, output, 1 bit each: downstream stage strobes.
REQ-014 SHALL have port conv_waddr, output, $clog2(CH) bits: dwconv weight and bias channel index.
REQ-015 SHALL have port fc2_waddr, output, $clog2(CH) bits: fc2 weight column index.
REQ-016 SHALL have port busy, output, 1 bit: asserted in any state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at run end.
REQ-018 SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-019 SHALL implement FSM states IDLE, FC1, GAP, DRAIN; transitions are REQ-020..REQ-024.
REQ-020 SHALL go IDLE->FC1 on start=1, clear all counters, and raise busy the next cycle; start outside IDLE is ignored.
REQ-021 SHALL, in FC1, drive in_valid_fc1=src_valid combinationally; fc1_waddr SHALL advance only on in_valid_fc1=1.
REQ-022 SHALL exit FC1 after the TOK_LEN-th accepted element (fc1_waddr=TOK_LEN-1 with src_valid=1), wrap fc1_waddr to 0, increment tok_cnt, and enter GAP.
REQ-023 SHALL count GAP cycles in GAP, then go to FC1 if tok_cnt<N_TOK, else to DRAIN.
REQ-024 SHALL, in DRAIN, pulse done one cycle and go to IDLE when out_cnt reaches N_TOK*TOK_LEN; the pulse and the IDLE entry SHALL occur together.
REQ-025 SHALL register in_valid_dwconv<=out_valid_fc1, in_valid_gelu<=out_valid_dwconv and in_valid_fc2<=out_valid_gelu, one-cycle latency each, independent of FSM state.
REQ-026 SHALL make conv_waddr the index for the current in_valid_dwconv beat, incrementing after each beat with wrap CH-1->0; fc2_waddr SHALL behave identically on in_valid_fc2 beats.
REQ-027 SHALL have out_cnt count out_valid beats while busy, width $clog2(N_TOK*TOK_LEN+1).
REQ-028 SHALL set err when out_valid=1 while not busy, or when out_cnt would exceed N_TOK*TOK_LEN; err clears only on reset or on an accepted start.
REQ-029 SHALL, if out_valid and the final GAP expiry coincide, count the beat before the DRAIN compare.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously drive state=IDLE, all valids=0, all addresses=0, tok_cnt=0, out_cnt=0, busy=0, done=0 and err=0.
REQ-031 SHALL, on reset mid-run, abandon the run; after release, no output activity occurs until a new start.

Verification
REQ-032 SHALL cover basic burst: start, src_valid=1 -> in_valid_fc1 high for 64 cycles with fc1_waddr 0..63, then low for exactly 192 cycles.
REQ-033 SHALL cover source stall: src_valid low for 5 cycles at element 10 -> fc1_waddr holds at 10 and the burst stretches to 69 cycles.
REQ-034 SHALL cover wrap: 300 out_valid_fc1 beats -> in_valid_dwconv lags by 1 cycle and conv_waddr reaches 255, then 0..43.
REQ-035 SHALL cover full run: N_TOK=2, model returns 128 out_valid -> done pulses once, with busy falling the same cycle.
REQ-036 SHALL cover protocol error: out_valid in IDLE -> err=1 and held until the next start.
REQ-037 SHALL cover reset mid-FC1 at element 30 -> all outputs 0 immediately; start ignored while rst_n=0.
